// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage MIPS pipeline.
// Holds the IF/ID pipeline register and the 32-entry register file. It decodes
// control, sign-extends the immediate and detects load-use and branch operand
// hazards. Branches and jumps are resolved here. Every ID_* output is
// combinational from IF/ID and the register file, and feeds the ID/EXE register.
module id_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] IF_pc_plus4,
   input  logic [DATA_W-1:0] IF_instr,
   input  logic              WB_reg_write,
   input  logic [RA_W-1:0]   WB_write_addr,
   input  logic [DATA_W-1:0] WB_write_data,
   input  logic              EXE_mem_read,
   input  logic              EXE_reg_write,
   input  logic [RA_W-1:0]   EXE_dest,
   input  logic              MEM_mem_read,
   input  logic [RA_W-1:0]   MEM_dest,
   output logic              pc_write,
   output logic [1:0]        pc_src,
   output logic [DATA_W-1:0] branch_target,
   output logic [DATA_W-1:0] jump_target,
   output logic              ID_mem_to_reg,
   output logic              ID_reg_write,
   output logic              ID_mem_write,
   output logic              ID_mem_read,
   output logic              ID_alu_src,
   output logic              ID_reg_dst,
   output logic [2:0]        ID_alu_op,
   output logic [DATA_W-1:0] ID_pc_plus4,
   output logic [DATA_W-1:0] ID_rs,
   output logic [DATA_W-1:0] ID_rt,
   output logic [DATA_W-1:0] ID_immediate,
   output logic [RA_W-1:0]   ID_reg_address_rs,
   output logic [RA_W-1:0]   ID_reg_address_rt,
   output logic [RA_W-1:0]   ID_reg_address_rd
);

   localparam int NUM_REGS = 1 << RA_W;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   logic [DATA_W-1:0] instr_q;
   logic [DATA_W-1:0] pc_plus4_q;
   logic [DATA_W-1:0] regs [NUM_REGS];

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [RA_W-1:0]   rs_addr;
   logic [RA_W-1:0]   rt_addr;
   logic [RA_W-1:0]   rd_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] imm_ext;

   logic              dec_mem_to_reg;
   logic              dec_reg_write;
   logic              dec_mem_write;
   logic              dec_mem_read;
   logic              dec_alu_src;
   logic              dec_reg_dst;
   logic [2:0]        dec_alu_op;
   logic              is_beq;
   logic              is_bne;
   logic              is_j;

   logic              load_use;
   logic              rs_dep;
   logic              rt_dep;
   logic              branch_hazard;
   logic              stall;
   logic              taken;
   logic              flush;

   assign opcode  = instr_q[31:26];
   assign funct   = instr_q[5:0];
   assign rs_addr = instr_q[25:21];
   assign rt_addr = instr_q[20:16];
   assign rd_addr = instr_q[15:11];
   assign imm_ext = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};

   // IF/ID register: a stall holds it, and a flush turns the incoming instruction into a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= '0;
         pc_plus4_q <= '0;
      end else if (stall) begin
         instr_q    <= instr_q;
         pc_plus4_q <= pc_plus4_q;
      end else if (flush) begin
         instr_q    <= '0;
         pc_plus4_q <= IF_pc_plus4;
      end else begin
         instr_q    <= IF_instr;
         pc_plus4_q <= IF_pc_plus4;
      end
   end

   // Register file write port; $0 is never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (WB_reg_write && (WB_write_addr != '0)) begin
         regs[WB_write_addr] <= WB_write_data;
      end
   end

   // Read ports: $0 reads zero, and a same-cycle writeback to the read address is forwarded
   always_comb begin
      rs_data = regs[rs_addr];
      rt_data = regs[rt_addr];
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (WB_reg_write && (WB_write_addr == rs_addr)) begin
         rs_data = WB_write_data;
      end
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (WB_reg_write && (WB_write_addr == rt_addr)) begin
         rt_data = WB_write_data;
      end
   end

   // Control decode; anything unrecognised decodes as a bubble
   always_comb begin
      dec_mem_to_reg = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_alu_src    = 1'b0;
      dec_reg_dst    = 1'b0;
      dec_alu_op     = ALU_ADD;
      is_beq         = 1'b0;
      is_bne         = 1'b0;
      is_j           = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_ADD; end
               FN_SUB: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_SUB; end
               FN_AND: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_AND; end
               FN_OR:  begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_OR;  end
               FN_SLT: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_SLT; end
               default: ;
            endcase
         end
         OP_LW: begin
            dec_alu_src    = 1'b1;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
         end
         OP_SW: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_ADDI: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_ADD; end
         OP_SLTI: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_SLT; end
         OP_ANDI: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_AND; end
         OP_ORI:  begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_op = ALU_OR;  end
         OP_BEQ:  is_beq = 1'b1;
         OP_BNE:  is_bne = 1'b1;
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   // Hazards: load-use on either source, or a branch operand still being produced in EXE/MEM
   always_comb begin
      load_use      = EXE_mem_read && (EXE_dest != '0) &&
                      ((EXE_dest == rs_addr) || (EXE_dest == rt_addr));
      rs_dep        = (rs_addr != '0) &&
                      ((EXE_reg_write && (EXE_dest == rs_addr)) || (MEM_mem_read && (MEM_dest == rs_addr)));
      rt_dep        = (rt_addr != '0) &&
                      ((EXE_reg_write && (EXE_dest == rt_addr)) || (MEM_mem_read && (MEM_dest == rt_addr)));
      branch_hazard = (is_beq || is_bne) && (rs_dep || rt_dep);
      stall         = load_use || branch_hazard;
   end

   // Next-PC selection; a taken branch or jump flushes the instruction fetched behind it
   always_comb begin
      taken    = (is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data));
      pc_write = !stall;
      pc_src   = PC_SEQ;
      flush    = 1'b0;
      if (!stall) begin
         if (taken) begin
            pc_src = PC_BRANCH;
            flush  = 1'b1;
         end else if (is_j) begin
            pc_src = PC_JUMP;
            flush  = 1'b1;
         end
      end
   end

   // A stall sends a bubble downstream by zeroing all control
   always_comb begin
      if (stall) begin
         ID_mem_to_reg = 1'b0;
         ID_reg_write  = 1'b0;
         ID_mem_write  = 1'b0;
         ID_mem_read   = 1'b0;
         ID_alu_src    = 1'b0;
         ID_reg_dst    = 1'b0;
         ID_alu_op     = ALU_ADD;
      end else begin
         ID_mem_to_reg = dec_mem_to_reg;
         ID_reg_write  = dec_reg_write;
         ID_mem_write  = dec_mem_write;
         ID_mem_read   = dec_mem_read;
         ID_alu_src    = dec_alu_src;
         ID_reg_dst    = dec_reg_dst;
         ID_alu_op     = dec_alu_op;
      end
   end

   assign branch_target     = pc_plus4_q + {imm_ext[DATA_W-3:0], 2'b00};
   assign jump_target       = {pc_plus4_q[DATA_W-1:DATA_W-4], instr_q[25:0], 2'b00};
   assign ID_pc_plus4       = pc_plus4_q;
   assign ID_rs             = rs_data;
   assign ID_rt             = rt_data;
   assign ID_immediate      = imm_ext;
   assign ID_reg_address_rs = rs_addr;
   assign ID_reg_address_rt = rt_addr;
   assign ID_reg_address_rd = rd_addr;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. It runs a decode vector table,
// directed multi-cycle sequences, and a randomized run against a reference model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] IF_pc_plus4 = '0;
   logic [31:0] IF_instr = '0;
   logic        WB_reg_write = 1'b0;
   logic [4:0]  WB_write_addr = '0;
   logic [31:0] WB_write_data = '0;
   logic        EXE_mem_read = 1'b0;
   logic        EXE_reg_write = 1'b0;
   logic [4:0]  EXE_dest = '0;
   logic        MEM_mem_read = 1'b0;
   logic [4:0]  MEM_dest = '0;

   logic        pc_write;
   logic [1:0]  pc_src;
   logic [31:0] branch_target, jump_target;
   logic        ID_mem_to_reg, ID_reg_write, ID_mem_write, ID_mem_read, ID_alu_src, ID_reg_dst;
   logic [2:0]  ID_alu_op;
   logic [31:0] ID_pc_plus4, ID_rs, ID_rt, ID_immediate;
   logic [4:0]  ID_reg_address_rs, ID_reg_address_rt, ID_reg_address_rd;

   int checks = 0;
   int errors = 0;

   id_stage #(.DATA_W(32), .RA_W(5)) dut (
      .clk(clk), .rst(rst),
      .IF_pc_plus4(IF_pc_plus4), .IF_instr(IF_instr),
      .WB_reg_write(WB_reg_write), .WB_write_addr(WB_write_addr), .WB_write_data(WB_write_data),
      .EXE_mem_read(EXE_mem_read), .EXE_reg_write(EXE_reg_write), .EXE_dest(EXE_dest),
      .MEM_mem_read(MEM_mem_read), .MEM_dest(MEM_dest),
      .pc_write(pc_write), .pc_src(pc_src),
      .branch_target(branch_target), .jump_target(jump_target),
      .ID_mem_to_reg(ID_mem_to_reg), .ID_reg_write(ID_reg_write), .ID_mem_write(ID_mem_write),
      .ID_mem_read(ID_mem_read), .ID_alu_src(ID_alu_src), .ID_reg_dst(ID_reg_dst),
      .ID_alu_op(ID_alu_op),
      .ID_pc_plus4(ID_pc_plus4), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_immediate(ID_immediate),
      .ID_reg_address_rs(ID_reg_address_rs), .ID_reg_address_rt(ID_reg_address_rt),
      .ID_reg_address_rd(ID_reg_address_rd)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Control bundle as {mem_to_reg, reg_write, mem_write, mem_read, alu_src, reg_dst, alu_op}
   logic [8:0] ctrl_bus;
   assign ctrl_bus = {ID_mem_to_reg, ID_reg_write, ID_mem_write, ID_mem_read,
                      ID_alu_src, ID_reg_dst, ID_alu_op};

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  ctrl;
      logic [2:0]  alu_op;
      logic [31:0] imm;
      logic [1:0]  pc_src;
   } vec_t;

   typedef struct {
      logic [31:0] if_pc;
      logic [31:0] if_instr;
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        exe_mr;
      logic        exe_rw;
      logic [4:0]  exe_dest;
      logic        mem_mr;
      logic [4:0]  mem_dest;
   } stim_t;

   typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_LW, M_SW, M_ADDI, M_SLTI,
                 M_ANDI, M_ORI, M_BEQ, M_BNE, M_J, M_NONE} mnem_t;

   vec_t vecs [16];

   // Reference model state: architectural registers plus the instruction held in decode
   logic [31:0] m_regs [32];
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [5:0]  e_ctrl;
   logic [2:0]  e_alu;
   logic        e_pc_write;
   logic [1:0]  e_pc_src;
   logic        e_stall;
   logic        e_flush;
   logic [31:0] e_bt, e_jt, e_rs, e_rt, e_imm;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      IF_pc_plus4   = s.if_pc;
      IF_instr      = s.if_instr;
      WB_reg_write  = s.wb_we;
      WB_write_addr = s.wb_addr;
      WB_write_data = s.wb_data;
      EXE_mem_read  = s.exe_mr;
      EXE_reg_write = s.exe_rw;
      EXE_dest      = s.exe_dest;
      MEM_mem_read  = s.mem_mr;
      MEM_dest      = s.mem_dest;
   endtask

   task automatic loadId(input logic [31:0] ins, input logic [31:0] pc);
      @(negedge clk);
      IF_instr    = ins;
      IF_pc_plus4 = pc;
      @(posedge clk);
      #1;
   endtask

   task automatic wbWrite(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      IF_instr      = '0;
      IF_pc_plus4   = '0;
      WB_reg_write  = 1'b1;
      WB_write_addr = addr;
      WB_write_data = data;
      @(posedge clk);
      #1;
      WB_reg_write  = 1'b0;
   endtask

   function automatic mnem_t classify(input logic [31:0] ins);
      logic [5:0] op = ins[31:26];
      logic [5:0] fn = ins[5:0];
      case (op)
         6'h00: case (fn)
                   6'h20: return M_ADD;
                   6'h22: return M_SUB;
                   6'h24: return M_AND;
                   6'h25: return M_OR;
                   6'h2A: return M_SLT;
                   default: return M_NONE;
                endcase
         6'h23: return M_LW;
         6'h2B: return M_SW;
         6'h08: return M_ADDI;
         6'h0A: return M_SLTI;
         6'h0C: return M_ANDI;
         6'h0D: return M_ORI;
         6'h04: return M_BEQ;
         6'h05: return M_BNE;
         6'h02: return M_J;
         default: return M_NONE;
      endcase
   endfunction

   // Control word {mem_to_reg, reg_write, mem_write, mem_read, alu_src, reg_dst, alu_op} per instruction
   function automatic logic [8:0] ctrlFor(input mnem_t m);
      case (m)
         M_ADD:  return {6'b010001, 3'd0};
         M_SUB:  return {6'b010001, 3'd1};
         M_AND:  return {6'b010001, 3'd2};
         M_OR:   return {6'b010001, 3'd3};
         M_SLT:  return {6'b010001, 3'd4};
         M_LW:   return {6'b110110, 3'd0};
         M_SW:   return {6'b001010, 3'd0};
         M_ADDI: return {6'b010010, 3'd0};
         M_SLTI: return {6'b010010, 3'd4};
         M_ANDI: return {6'b010010, 3'd2};
         M_ORI:  return {6'b010010, 3'd3};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] readReg(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (WB_reg_write && WB_write_addr == a) return WB_write_data;
      return m_regs[a];
   endfunction

   function automatic logic pendingWriter(input logic [4:0] r);
      return (r != 0) && ((EXE_reg_write && EXE_dest == r) || (MEM_mem_read && MEM_dest == r));
   endfunction

   task automatic computeExpected();
      mnem_t       m = classify(m_instr);
      logic [4:0]  a_rs = m_instr[25:21];
      logic [4:0]  a_rt = m_instr[20:16];
      logic        is_br = (m == M_BEQ) || (m == M_BNE);
      logic        tk;
      logic [8:0]  c;
      e_rs  = readReg(a_rs);
      e_rt  = readReg(a_rt);
      e_imm = {{16{m_instr[15]}}, m_instr[15:0]};
      e_bt  = m_pc + e_imm * 32'd4;
      e_jt  = {m_pc[31:28], m_instr[25:0], 2'b00};
      e_stall = (EXE_mem_read && EXE_dest != 0 && (EXE_dest == a_rs || EXE_dest == a_rt)) ||
                (is_br && (pendingWriter(a_rs) || pendingWriter(a_rt)));
      tk = ((m == M_BEQ) && (e_rs == e_rt)) || ((m == M_BNE) && (e_rs != e_rt));
      e_pc_write = !e_stall;
      e_pc_src   = e_stall ? 2'b00 : tk ? 2'b01 : (m == M_J) ? 2'b10 : 2'b00;
      e_flush    = !e_stall && (tk || m == M_J);
      c = e_stall ? 9'd0 : ctrlFor(m);
      e_ctrl = c[8:3];
      e_alu  = c[2:0];
   endtask

   task automatic updateModel();
      if (WB_reg_write && WB_write_addr != 0) m_regs[WB_write_addr] = WB_write_data;
      if (!e_stall) begin
         m_instr = e_flush ? 32'd0 : IF_instr;
         m_pc    = IF_pc_plus4;
      end
   endtask

   function automatic logic [31:0] genInstr();
      int          k  = $urandom_range(0, 17);
      logic [4:0]  rs = 5'($urandom_range(0, 7));
      logic [4:0]  rt = 5'($urandom_range(0, 7));
      logic [4:0]  rd = 5'($urandom_range(0, 7));
      logic [4:0]  sh = 5'($urandom_range(0, 31));
      logic [15:0] im = 16'($urandom);
      case (k)
         0:  return {6'h00, rs, rt, rd, sh, 6'h20};
         1:  return {6'h00, rs, rt, rd, sh, 6'h22};
         2:  return {6'h00, rs, rt, rd, sh, 6'h24};
         3:  return {6'h00, rs, rt, rd, sh, 6'h25};
         4:  return {6'h00, rs, rt, rd, sh, 6'h2A};
         5:  return {6'h00, rs, rt, rd, sh, 6'($urandom)};
         6:  return {6'h23, rs, rt, im};
         7:  return {6'h2B, rs, rt, im};
         8:  return {6'h08, rs, rt, im};
         9:  return {6'h0A, rs, rt, im};
         10: return {6'h0C, rs, rt, im};
         11: return {6'h0D, rs, rt, im};
         12, 16: return {6'h04, rs, rt, im};
         13, 17: return {6'h05, rs, rt, im};
         14: return {6'h02, 26'($urandom)};
         default: return $urandom;
      endcase
   endfunction

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      stim_t s;

      vecs[0]  = '{32'h01034820, 6'b010001, 3'd0, 32'h00004820, 2'b00}; // add $9,$8,$3
      vecs[1]  = '{32'h00430822, 6'b010001, 3'd1, 32'h00000822, 2'b00}; // sub
      vecs[2]  = '{32'h00A62024, 6'b010001, 3'd2, 32'h00002024, 2'b00}; // and
      vecs[3]  = '{32'h00223825, 6'b010001, 3'd3, 32'h00003825, 2'b00}; // or
      vecs[4]  = '{32'h0085182A, 6'b010001, 3'd4, 32'h0000182A, 2'b00}; // slt
      vecs[5]  = '{32'h8C480004, 6'b110110, 3'd0, 32'h00000004, 2'b00}; // lw $8,4($2)
      vecs[6]  = '{32'hAC48FFF8, 6'b001010, 3'd0, 32'hFFFFFFF8, 2'b00}; // sw $8,-8($2)
      vecs[7]  = '{32'h2004FFFF, 6'b010010, 3'd0, 32'hFFFFFFFF, 2'b00}; // addi $4,$0,-1
      vecs[8]  = '{32'h28250064, 6'b010010, 3'd4, 32'h00000064, 2'b00}; // slti
      vecs[9]  = '{32'h30268000, 6'b010010, 3'd2, 32'hFFFF8000, 2'b00}; // andi, sign-extended
      vecs[10] = '{32'h342600FF, 6'b010010, 3'd3, 32'h000000FF, 2'b00}; // ori
      vecs[11] = '{32'hFC221234, 6'b000000, 3'd0, 32'h00001234, 2'b00}; // illegal opcode 0x3F
      vecs[12] = '{32'h00221821, 6'b000000, 3'd0, 32'h00001821, 2'b00}; // unsupported funct
      vecs[13] = '{32'h08000040, 6'b000000, 3'd0, 32'h00000040, 2'b10}; // j
      vecs[14] = '{32'h10000003, 6'b000000, 3'd0, 32'h00000003, 2'b01}; // beq $0,$0 taken
      vecs[15] = '{32'h14000003, 6'b000000, 3'd0, 32'h00000003, 2'b00}; // bne $0,$0 not taken

      // Reset state
      #12 rst = 1'b0;
      #1;
      checkOutput("reset_ctrl", ctrl_bus, 9'd0);
      checkOutput("reset_pc", {pc_write, pc_src}, 3'b100);
      checkOutput("reset_targets", {branch_target, jump_target}, 64'd0);
      checkOutput("reset_data", {ID_rs, ID_rt}, 64'd0);
      checkOutput("reset_imm_pc", {ID_immediate, ID_pc_plus4}, 64'd0);

      // Register file writes, $0 protection, write-first bypass
      wbWrite(5'd5, 32'h1234);
      wbWrite(5'd0, 32'hFFFF);
      loadId(32'h00A00820, 32'h4);               // add $1,$5,$0
      checkOutput("rf_read5", ID_rs, 32'h1234);
      checkOutput("rf_read0", ID_rt, 32'h0);
      loadId(32'h00E00820, 32'h8);               // add $1,$7,$0
      WB_reg_write = 1'b1; WB_write_addr = 5'd7; WB_write_data = 32'hCAFE;
      #1;
      checkOutput("rf_bypass7", ID_rs, 32'hCAFE);
      @(posedge clk); #1;
      WB_reg_write = 1'b0;
      #1;
      checkOutput("rf_stored7", ID_rs, 32'hCAFE);
      WB_reg_write = 1'b1; WB_write_addr = 5'd0; WB_write_data = 32'hBEEF;
      #1;
      checkOutput("rf_bypass0", ID_rt, 32'h0);
      WB_reg_write = 1'b0;

      // Load-use stall: lw $8 in EXE, add $9,$8,$3 in ID
      loadId(32'h01034820, 32'h20);
      EXE_mem_read = 1'b1; EXE_dest = 5'd8;
      IF_instr = 32'h00223825; IF_pc_plus4 = 32'h24;
      #1;
      checkOutput("lu_pc_write", pc_write, 1'b0);
      checkOutput("lu_ctrl", ctrl_bus, 9'd0);
      @(posedge clk); #1;
      checkOutput("lu_hold", {ID_reg_address_rd, ID_pc_plus4}, {5'd9, 32'h20});
      EXE_dest = 5'd3;
      #1;
      checkOutput("lu_rt_stall", pc_write, 1'b0);
      EXE_mem_read = 1'b0; EXE_dest = 5'd0;
      #1;
      checkOutput("lu_release", {pc_write, ctrl_bus}, {1'b1, 6'b010001, 3'd0});
      @(posedge clk); #1;
      checkOutput("lu_advance", {ID_reg_address_rd, ID_pc_plus4}, {5'd7, 32'h24});

      // Taken beq with flush
      wbWrite(5'd1, 32'd5);
      wbWrite(5'd2, 32'd5);
      loadId(32'h10220003, 32'h104);             // beq $1,$2,+3
      checkOutput("beq_pc", {pc_write, pc_src}, 3'b101);
      checkOutput("beq_target", branch_target, 32'h110);
      checkOutput("beq_ctrl", ctrl_bus, 9'd0);
      IF_instr = 32'h00223825; IF_pc_plus4 = 32'h108;
      @(posedge clk); #1;
      checkOutput("beq_flush", {ID_immediate, ID_pc_plus4}, {32'h0, 32'h108});

      // Branch operand hazard from EXE, then MEM load, then resolution
      loadId(32'h10220003, 32'h104);
      EXE_reg_write = 1'b1; EXE_dest = 5'd1;
      IF_instr = 32'h00223825; IF_pc_plus4 = 32'h108;
      #1;
      checkOutput("bhz_exe", {pc_write, pc_src}, 3'b000);
      @(posedge clk); #1;
      checkOutput("bhz_hold", ID_immediate, 32'h3);
      EXE_reg_write = 1'b0; EXE_dest = 5'd0;
      MEM_mem_read = 1'b1; MEM_dest = 5'd2;
      #1;
      checkOutput("bhz_mem", {pc_write, pc_src}, 3'b000);
      MEM_mem_read = 1'b0; MEM_dest = 5'd0;
      #1;
      checkOutput("bhz_resolved", {pc_write, pc_src}, 3'b101);
      @(posedge clk); #1;
      checkOutput("bhz_flush", ID_immediate, 32'h0);

      // Jump
      loadId(32'h08000040, 32'h10000004);
      checkOutput("j_target", jump_target, 32'h10000100);
      checkOutput("j_pc", {pc_write, pc_src}, 3'b110);
      IF_instr = 32'h00223825; IF_pc_plus4 = 32'h10000008;
      @(posedge clk); #1;
      checkOutput("j_flush", ID_immediate, 32'h0);

      // Reset while stalled
      loadId(32'h00A00820, 32'h30);              // add $1,$5,$0
      EXE_mem_read = 1'b1; EXE_dest = 5'd5;
      #1;
      checkOutput("rst_stall_pre", pc_write, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("rst_stall_release", {pc_write, pc_src, ctrl_bus}, {3'b100, 9'd0});
      checkOutput("rst_stall_ifid", {ID_pc_plus4, ID_immediate}, 64'd0);
      rst = 1'b0; EXE_mem_read = 1'b0; EXE_dest = 5'd0;
      loadId(32'h00A00820, 32'h34);
      checkOutput("rst_rf_cleared", ID_rs, 32'h0);

      // Decode vector table
      for (int i = 0; i < 16; i++) begin
         loadId(vecs[i].instr, 32'h400);
         checkOutput($sformatf("vec%0d_ctrl", i), ctrl_bus, {vecs[i].ctrl, vecs[i].alu_op});
         checkOutput($sformatf("vec%0d_imm", i), ID_immediate, vecs[i].imm);
         checkOutput($sformatf("vec%0d_pc", i), {pc_write, pc_src}, {1'b1, vecs[i].pc_src});
         checkOutput($sformatf("vec%0d_addr", i),
                     {ID_reg_address_rs, ID_reg_address_rt, ID_reg_address_rd},
                     {vecs[i].instr[25:21], vecs[i].instr[20:16], vecs[i].instr[15:11]});
         loadId(32'h0, 32'h0);
      end

      // Randomized run against the reference model
      @(negedge clk);
      s = '{default: '0};
      applyStimulus(s);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_instr = '0;
      m_pc    = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         s.if_instr = genInstr();
         s.if_pc    = $urandom;
         s.wb_we    = ($urandom_range(0, 9) < 4);
         s.wb_addr  = 5'($urandom_range(0, 7));
         s.wb_data  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
         s.exe_mr   = ($urandom_range(0, 3) == 0);
         s.exe_rw   = ($urandom_range(0, 9) < 3);
         s.exe_dest = 5'($urandom_range(0, 7));
         s.mem_mr   = ($urandom_range(0, 3) == 0);
         s.mem_dest = 5'($urandom_range(0, 7));
         applyStimulus(s);
         #2;
         computeExpected();
         checkOutput("rand_ctrl", ctrl_bus, {e_ctrl, e_alu});
         checkOutput("rand_pc", {pc_write, pc_src}, {e_pc_write, e_pc_src});
         checkOutput("rand_targets", {branch_target, jump_target}, {e_bt, e_jt});
         checkOutput("rand_regs", {ID_rs, ID_rt}, {e_rs, e_rt});
         checkOutput("rand_imm_pc", {ID_immediate, ID_pc_plus4}, {e_imm, m_pc});
         checkOutput("rand_addr", {ID_reg_address_rs, ID_reg_address_rt, ID_reg_address_rd},
                     {m_instr[25:21], m_instr[20:16], m_instr[15:11]});
         @(posedge clk);
         updateModel();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
